keypad_code_entry: RTL

Upstream entry stage for `digital_lock_system`. It collects single-bit key presses from the keypad front end MSB-first into a 4-bit candidate code. On a valid ENTER it presents the code on a registered `code` bus with a one-cycle `code_valid` strobe, and the lock compares it. It also handles clear, short or long entries, and idle timeout, so the lock only ever sees complete codes.

---
 rtl/keypad_code_entry.sv | 93 +++++++++
 1 files changed

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: gathers MSB-first key bits into a 4-bit code
// and submits it to the lock on ENTER, with clear/overflow/timeout.
module keypad_code_entry #(
  parameter int CODE_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic                 key_bit,
  input  logic                 key_enter,
  input  logic                 key_clear,
  output logic [CODE_BITS-1:0] code,
  output logic                 code_valid,
  output logic                 entry_error,
  output logic                 timeout,
  output logic [2:0]           digit_count
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] CLAST = 3'(CODE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL,
    OVERFLOW
  } state_t;

  state_t               state;
  logic [CODE_BITS-1:0] sr;
  logic [TW-1:0]        timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      timer       <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      digit_count <= 3'd0;
    end else begin
      code_valid  <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      if (key_clear) begin
        state       <= IDLE;
        sr          <= '0;
        timer       <= '0;
        digit_count <= 3'd0;
      end else if (key_enter) begin
        if (state == FULL) begin
          code       <= sr;
          code_valid <= 1'b1;
        end else begin
          entry_error <= 1'b1;
        end
        state       <= IDLE;
        sr          <= '0;
        timer       <= '0;
        digit_count <= 3'd0;
      end else if (key_valid) begin
        timer <= '0;
        unique case (state)
          IDLE, COLLECT: begin
            sr          <= {sr[CODE_BITS-2:0], key_bit};
            digit_count <= digit_count + 3'd1;
            state       <= (digit_count == CLAST) ? FULL : COLLECT;
          end
          FULL:     state <= OVERFLOW;
          OVERFLOW: state <= OVERFLOW;
          default:  state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // partial entry expires once the timer has run its full span
        if (timer == TLAST) begin
          timeout     <= 1'b1;
          state       <= IDLE;
          sr          <= '0;
          timer       <= '0;
          digit_count <= 3'd0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule
